pipeline_skid_register: RTL

// - Parametrised pipeline stage register with a valid/ready handshake, a 2-entry skid buffer and a synchronous flush.
// - Sits between MIPS pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB) in place of plain enable registers.
// - Stalls from downstream propagate upstream one cycle later with no bubble.
// - Sustains one transfer per cycle.
//

---
 rtl/pipeline_skid_register_if.sv | 34 +++
 rtl/pipeline_skid_register.sv | 113 +++++++++++
 2 files changed

// File: rtl/pipeline_skid_register_if.sv
// rtl/pipeline_skid_register_if.sv - upstream/downstream handshake bundle for pipeline_skid_register
interface pipeline_skid_register_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] InData;
    logic             InValid;
    logic             InReady;
    logic             Flush;
    logic [WIDTH-1:0] OutData;
    logic             OutValid;
    logic             OutReady;

    // master: the surrounding pipeline (producer side plus consumer's ready)
    modport master (
        output InData,
        output InValid,
        output Flush,
        output OutReady,
        input  InReady,
        input  OutData,
        input  OutValid
    );

    // slave: the stage register itself
    modport slave (
        input  InData,
        input  InValid,
        input  Flush,
        input  OutReady,
        output InReady,
        output OutData,
        output OutValid
    );
endinterface

// File: rtl/pipeline_skid_register.sv
// rtl/pipeline_skid_register.sv - valid/ready pipeline stage with 2-entry skid buffer and flush
// Optional stall counter output enabled by defining PIPE_REG_STALL_COUNT_EN.
module pipeline_skid_register #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                        Clock,
    input  logic                        Resetn,
    pipeline_skid_register_if.slave     bus
`ifdef PIPE_REG_STALL_COUNT_EN
    ,
    output logic [31:0]                 StallCount
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e           state_q,    state_d;
    logic             in_ready_q, in_ready_d;
    logic [WIDTH-1:0] main_q,     main_d;
    logic [WIDTH-1:0] skid_q,     skid_d;

    logic out_valid;
    logic accept;
    logic take;

    assign out_valid = (state_q != EMPTY);
    assign accept    = bus.InValid & in_ready_q;
    assign take      = out_valid & bus.OutReady;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b0;
            main_q     <= RESET_VALUE;
            skid_q     <= RESET_VALUE;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        // Flush empties the stage but leaves data registers untouched.
        if (bus.Flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d = HALF;
                        main_d  = bus.InData;
                    end
                end
                HALF: begin
                    if (accept && take) begin
                        main_d = bus.InData;
                    end else if (accept) begin
                        state_d = FULL;
                        skid_d  = bus.InData;
                    end else if (take) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (take) begin
                        state_d = HALF;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
        in_ready_d = (state_d != FULL);
    end

    assign bus.OutData  = main_q;
    assign bus.OutValid = out_valid;
    assign bus.InReady  = in_ready_q;

`ifdef PIPE_REG_STALL_COUNT_EN
    logic [31:0] stall_count_q, stall_count_d;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            stall_count_q <= 32'd0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (out_valid && !bus.OutReady && !bus.Flush && (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    assign StallCount = stall_count_q;
`endif

endmodule
